// File: rtl/alu_share_arbiter.sv
// Round-robin share of one combinational ADD/CMP ALU between two requesters.
// IDLE latches the granted operands, EXEC captures the ALU result, RESP holds it until consumed.
module alu_share_arbiter #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic [1:0]   req_valid,
  input  logic [N-1:0] req_a0,
  input  logic [N-1:0] req_a1,
  input  logic [N-1:0] req_b0,
  input  logic [N-1:0] req_b1,
  input  logic [1:0]   req_s,
  output logic [1:0]   req_ready,
  output logic [1:0]   rsp_valid,
  input  logic [1:0]   rsp_ready,
  output logic [N-1:0] rsp_y,
  output logic         rsp_zf,
  output logic [N-1:0] alu_a,
  output logic [N-1:0] alu_b,
  output logic         alu_s,
  input  logic [N-1:0] alu_y,
  input  logic         alu_zf,
  output logic         busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0] r_state;
  logic       r_last_grant;
  logic       r_gnt_id;
  logic       w_grant;
  logic       w_accept;

  // On a tie the requester that was not served last wins.
  always_comb begin
    w_grant  = (req_valid == 2'b11) ? ~r_last_grant : req_valid[1];
    w_accept = (r_state == IDLE) && (req_valid != 2'b00);
  end

  always_comb begin
    req_ready = 2'b00;
    if (w_accept && rstn)
      req_ready = w_grant ? 2'b10 : 2'b01;
    rsp_valid = 2'b00;
    if (r_state == RESP)
      rsp_valid = r_gnt_id ? 2'b10 : 2'b01;
    busy = (r_state != IDLE);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state      <= IDLE;
      r_last_grant <= 1'b1;
      r_gnt_id     <= 1'b0;
      alu_a        <= '0;
      alu_b        <= '0;
      alu_s        <= 1'b0;
      rsp_y        <= '0;
      rsp_zf       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            alu_a    <= w_grant ? req_a1 : req_a0;
            alu_b    <= w_grant ? req_b1 : req_b0;
            alu_s    <= req_s[w_grant];
            r_gnt_id <= w_grant;
            r_state  <= EXEC;
          end
        end
        EXEC: begin
          rsp_y   <= alu_y;
          rsp_zf  <= alu_zf;
          r_state <= RESP;
        end
        RESP: begin
          // Only the owner of the response can release it.
          if (rsp_ready[r_gnt_id]) begin
            r_last_grant <= r_gnt_id;
            r_state      <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboard bench for alu_share_arbiter: directed scenarios plus random traffic,
// with a transaction-level reference model and a decoupled response monitor.
module tb_alu_share_arbiter;

  typedef struct packed {
    logic        gid;
    logic [31:0] y;
    logic        zf;
  } rsp_t;

  logic        clk;
  logic        rstn;
  logic [1:0]  reqValid;
  logic [31:0] reqA0, reqA1, reqB0, reqB1;
  logic [1:0]  reqS;
  logic [1:0]  reqReady;
  logic [1:0]  rspValid;
  logic [1:0]  rspReady;
  logic [31:0] rspY;
  logic        rspZf;
  logic [31:0] aluA, aluB;
  logic        aluS;
  logic [31:0] aluY;
  logic        aluZf;
  logic        busy;

  int testsRun = 0;
  int testsFailed = 0;

  rsp_t sbQ[$];

  // Transaction-level model: one outstanding op, cycles counted since acceptance.
  bit          mdlBusy;
  int          mdlAge;
  bit          mdlGid;
  bit          mdlLast;
  logic [31:0] mdlAluA, mdlAluB;
  logic        mdlAluS;

  alu_share_arbiter #(.N(32)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(reqValid),
    .req_a0(reqA0), .req_a1(reqA1), .req_b0(reqB0), .req_b1(reqB1),
    .req_s(reqS), .req_ready(reqReady),
    .rsp_valid(rspValid), .rsp_ready(rspReady),
    .rsp_y(rspY), .rsp_zf(rspZf),
    .alu_a(aluA), .alu_b(aluB), .alu_s(aluS),
    .alu_y(aluY), .alu_zf(aluZf),
    .busy(busy)
  );

  // The shared ALU the arbiter drives.
  assign aluY  = aluS ? (aluA ^ aluB) : (aluA + aluB);
  assign aluZf = (aluY == 32'd0);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [1:0] oneHot(input bit idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

  task automatic modelReset();
    mdlBusy = 0; mdlAge = 0; mdlGid = 0; mdlLast = 1;
    mdlAluA = '0; mdlAluB = '0; mdlAluS = 1'b0;
    sbQ.delete();
  endtask

  task automatic checkOutput();
    logic [1:0] expReady;
    logic [1:0] expRsp;
    bit         g;
    expReady = 2'b00;
    expRsp   = 2'b00;
    g = (reqValid == 2'b11) ? !mdlLast : reqValid[1];
    if (!mdlBusy && reqValid != 2'b00) expReady = oneHot(g);
    if (mdlBusy && mdlAge >= 1) expRsp = oneHot(mdlGid);
    check("req_ready", {30'd0, reqReady}, {30'd0, expReady});
    check("rsp_valid", {30'd0, rspValid}, {30'd0, expRsp});
    check("busy", {31'd0, busy}, {31'd0, mdlBusy});
    check("alu_a", aluA, mdlAluA);
    check("alu_b", aluB, mdlAluB);
    check("alu_s", {31'd0, aluS}, {31'd0, mdlAluS});
  endtask

  task automatic modelEdge();
    bit          g;
    rsp_t        r;
    logic [31:0] a, b;
    if (mdlBusy) begin
      if (mdlAge >= 1 && rspReady[mdlGid]) begin
        mdlBusy = 0;
        mdlLast = mdlGid;
      end else if (mdlAge < 1) begin
        mdlAge++;
      end
    end else if (reqValid != 2'b00) begin
      g = (reqValid == 2'b11) ? !mdlLast : reqValid[1];
      a = g ? reqA1 : reqA0;
      b = g ? reqB1 : reqB0;
      mdlAluA = a; mdlAluB = b; mdlAluS = reqS[g];
      r.gid = g;
      r.y   = reqS[g] ? (a ^ b) : (a + b);
      r.zf  = (r.y == 32'd0);
      sbQ.push_back(r);
      mdlBusy = 1; mdlAge = 0; mdlGid = g;
    end
  endtask

  task automatic applyStimulus(input logic [1:0] v, input logic [31:0] a0, input logic [31:0] b0,
                               input logic [31:0] a1, input logic [31:0] b1,
                               input logic [1:0] s, input logic [1:0] rr);
    @(negedge clk);
    reqValid = v; reqA0 = a0; reqB0 = b0; reqA1 = a1; reqB1 = b1; reqS = s; rspReady = rr;
    #1 checkOutput();
    @(posedge clk);
    modelEdge();
  endtask

  // Monitor: every presented response must match the oldest outstanding expectation.
  initial begin
    rsp_t exp;
    forever begin
      @(negedge clk);
      #2;
      if (rstn && rspValid != 2'b00) begin
        if (sbQ.size() == 0) begin
          check("rsp_unexpected", {30'd0, rspValid}, 32'd0);
        end else begin
          exp = sbQ[0];
          check("rsp_owner", {30'd0, rspValid}, {30'd0, oneHot(exp.gid)});
          check("rsp_y", rspY, exp.y);
          check("rsp_zf", {31'd0, rspZf}, {31'd0, exp.zf});
          if (rspReady[exp.gid]) void'(sbQ.pop_front());
        end
      end
    end
  end

  initial begin
    #1000000;
    testsFailed++;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  initial begin
    logic [31:0] a0, b0, a1, b1;
    logic [1:0]  rr;
    modelReset();
    rstn = 1'b0;
    reqValid = 2'b11; reqA0 = 32'h1; reqB0 = 32'h2; reqA1 = 32'h3; reqB1 = 32'h4;
    reqS = 2'b00; rspReady = 2'b00;
    #12;
    check("reset_req_ready", {30'd0, reqReady}, 32'd0);
    check("reset_rsp_valid", {30'd0, rspValid}, 32'd0);
    check("reset_rsp_y", rspY, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_alu_a", aluA, 32'd0);
    @(negedge clk);
    reqValid = 2'b00;
    @(negedge clk);
    rstn = 1'b1;

    // Single ADD from requester 0, consumed immediately.
    applyStimulus(2'b01, 32'd5, 32'd7, 32'd0, 32'd0, 2'b00, 2'b00);
    applyStimulus(2'b00, 32'd0, 32'd0, 32'd0, 32'd0, 2'b00, 2'b00);
    applyStimulus(2'b00, 32'd0, 32'd0, 32'd0, 32'd0, 2'b00, 2'b01);
    applyStimulus(2'b00, 32'd0, 32'd0, 32'd0, 32'd0, 2'b00, 2'b00);

    // Continuous contention must alternate.
    for (int i = 0; i < 12; i++)
      applyStimulus(2'b11, i, i + 1, 100 + i, 200 + i, 2'b00, 2'b11);

    // CMP equal/unequal and ADD wrap.
    for (int i = 0; i < 3; i++)
      applyStimulus(2'b10, 32'd0, 32'd0, 32'hDEADBEEF, 32'hDEADBEEF, 2'b10, 2'b11);
    for (int i = 0; i < 3; i++)
      applyStimulus(2'b10, 32'd0, 32'd0, 32'd1, 32'd3, 2'b10, 2'b11);
    for (int i = 0; i < 3; i++)
      applyStimulus(2'b01, 32'hFFFFFFFF, 32'd1, 32'd0, 32'd0, 2'b00, 2'b11);

    // Backpressure, then a release attempt on the wrong bit.
    applyStimulus(2'b11, 32'd9, 32'd9, 32'd10, 32'd11, 2'b01, 2'b00);
    for (int i = 0; i < 7; i++)
      applyStimulus(2'b11, 32'd9, 32'd9, 32'd10, 32'd11, 2'b01, 2'b00);
    applyStimulus(2'b11, 32'd9, 32'd9, 32'd10, 32'd11, 2'b01, ~oneHot(mdlGid));
    applyStimulus(2'b11, 32'd9, 32'd9, 32'd10, 32'd11, 2'b01, 2'b11);
    applyStimulus(2'b00, 32'd0, 32'd0, 32'd0, 32'd0, 2'b00, 2'b11);
    applyStimulus(2'b00, 32'd0, 32'd0, 32'd0, 32'd0, 2'b00, 2'b11);
    applyStimulus(2'b00, 32'd0, 32'd0, 32'd0, 32'd0, 2'b00, 2'b11);

    // Asynchronous reset during EXEC drops the operation.
    applyStimulus(2'b10, 32'd0, 32'd0, 32'd77, 32'd88, 2'b00, 2'b11);
    #3 rstn = 1'b0;
    #1;
    check("midreset_busy", {31'd0, busy}, 32'd0);
    check("midreset_rsp_valid", {30'd0, rspValid}, 32'd0);
    check("midreset_req_ready", {30'd0, reqReady}, 32'd0);
    check("midreset_alu_a", aluA, 32'd0);
    check("midreset_rsp_y", rspY, 32'd0);
    modelReset();
    @(negedge clk);
    reqValid = 2'b00;
    rstn = 1'b1;
    for (int i = 0; i < 3; i++)
      applyStimulus(2'b00, 32'd0, 32'd0, 32'd0, 32'd0, 2'b00, 2'b11);
    applyStimulus(2'b11, 32'd4, 32'd4, 32'd6, 32'd6, 2'b11, 2'b11);
    check("post_reset_tie_grant0", {31'd0, mdlGid}, 32'd0);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      a0 = $urandom; a1 = $urandom;
      b0 = ($urandom_range(0, 3) == 0) ? a0 : $urandom;
      b1 = ($urandom_range(0, 3) == 0) ? (32'd0 - a1) : $urandom;
      rr = ($urandom_range(0, 2) == 0) ? 2'b00 : 2'($urandom_range(0, 3));
      applyStimulus(2'($urandom_range(0, 3)), a0, b0, a1, b1, 2'($urandom_range(0, 3)), rr);
    end

    for (int i = 0; i < 6; i++)
      applyStimulus(2'b00, 32'd0, 32'd0, 32'd0, 32'd0, 2'b00, 2'b11);
    check("drain_empty", sbQ.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
